// File: rtl/mon_commit_serializer.sv
// Multi-lane retirement collector: checks program order and post-halt activity,
// buffers accepted packets in a circular FIFO and replays them one per cycle.
module mon_commit_serializer #(
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 8,
  parameter int XLEN     = 32,
  parameter int ORDER_W  = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CHANNELS-1:0]         in_valid,
  input  logic [CHANNELS*ORDER_W-1:0] in_order,
  input  logic [CHANNELS*32-1:0]      in_inst,
  input  logic [CHANNELS*XLEN-1:0]    in_pc_rdata,
  input  logic [CHANNELS*XLEN-1:0]    in_pc_wdata,
  input  logic [CHANNELS-1:0]         in_load_regfile,
  input  logic [CHANNELS*5-1:0]       in_rd_addr,
  input  logic [CHANNELS*XLEN-1:0]    in_rd_wdata,
  input  logic [CHANNELS-1:0]         in_halt,
  output logic                        in_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ORDER_W-1:0]          out_order,
  output logic [31:0]                 out_inst,
  output logic [XLEN-1:0]             out_pc_rdata,
  output logic [XLEN-1:0]             out_pc_wdata,
  output logic                        out_load_regfile,
  output logic [4:0]                  out_rd_addr,
  output logic [XLEN-1:0]             out_rd_wdata,
  output logic                        out_halt,
  output logic [ORDER_W-1:0]          commit_count,
  output logic                        halt_seen,
  output logic                        error,
  output logic [1:0]                  error_code
);

  // Handshake: input side transfers when |in_valid && in_ready (in_ready is
  // registered); output side transfers when out_valid && out_ready.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [1:0] ERR_ORDER    = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW = 2'd2;
  localparam logic [1:0] ERR_POSTHALT = 2'd3;

  typedef struct packed {
    logic [ORDER_W-1:0] order;
    logic [31:0]        inst;
    logic [XLEN-1:0]    pc_rdata;
    logic [XLEN-1:0]    pc_wdata;
    logic               load_regfile;
    logic [4:0]         rd_addr;
    logic [XLEN-1:0]    rd_wdata;
    logic               halt;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   head_q, tail_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               in_ready_q, in_ready_d;
  logic [ORDER_W-1:0] exp_order_q, exp_order_d;
  logic [ORDER_W-1:0] commit_count_q;
  logic               halt_seen_q;
  logic               error_q;
  logic [1:0]         error_code_q;

  entry_t             lane_e   [CHANNELS];
  logic               wr_en    [CHANNELS];
  logic [PTR_W-1:0]   wr_slot  [CHANNELS];
  logic [CNT_W-1:0]   n_push;
  logic [ORDER_W-1:0] exp_run;
  logic               halt_run;
  logic               any_valid, accept, overflow, pop;
  logic               order_err, post_halt_err, new_halt, err_any;
  logic [1:0]         code_d;
  entry_t             head_e;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      lane_e[i].order        = in_order[i*ORDER_W +: ORDER_W];
      lane_e[i].inst         = in_inst[i*32 +: 32];
      lane_e[i].pc_rdata     = in_pc_rdata[i*XLEN +: XLEN];
      lane_e[i].pc_wdata     = in_pc_wdata[i*XLEN +: XLEN];
      lane_e[i].load_regfile = in_load_regfile[i];
      lane_e[i].rd_addr      = in_rd_addr[i*5 +: 5];
      lane_e[i].rd_wdata     = in_rd_wdata[i*XLEN +: XLEN];
      lane_e[i].halt         = in_halt[i];
    end
  end

  // Lanes are walked oldest first so the order and halt checks see program order.
  always_comb begin
    any_valid     = |in_valid;
    accept        = any_valid && in_ready_q;
    overflow      = any_valid && !in_ready_q;
    exp_run       = exp_order_q;
    halt_run      = halt_seen_q;
    order_err     = 1'b0;
    post_halt_err = 1'b0;
    new_halt      = 1'b0;
    n_push        = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr_en[i]   = 1'b0;
      wr_slot[i] = '0;
      if (accept && in_valid[i]) begin
        wr_en[i]   = 1'b1;
        wr_slot[i] = tail_q + n_push[PTR_W-1:0];
        n_push     = n_push + CNT_W'(1);
        if (lane_e[i].order != exp_run) order_err = 1'b1;
        if (halt_run) post_halt_err = 1'b1;
        if (lane_e[i].halt) begin
          halt_run = 1'b1;
          new_halt = 1'b1;
        end
        exp_run = lane_e[i].order + ORDER_W'(1);
      end
    end
    exp_order_d = exp_run;
  end

  always_comb begin
    out_valid  = (count_q != '0);
    pop        = out_valid && out_ready;
    count_d    = count_q + n_push - CNT_W'(pop);
    in_ready_d = (DEPTH - int'(count_d)) >= CHANNELS;
    err_any    = overflow || order_err || post_halt_err;
    if (overflow)       code_d = ERR_OVERFLOW;
    else if (order_err) code_d = ERR_ORDER;
    else                code_d = ERR_POSTHALT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      in_ready_q     <= 1'b1;
      exp_order_q    <= '0;
      commit_count_q <= '0;
      halt_seen_q    <= 1'b0;
      error_q        <= 1'b0;
      error_code_q   <= 2'd0;
    end else begin
      head_q      <= head_q + PTR_W'(pop);
      tail_q      <= tail_q + n_push[PTR_W-1:0];
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      exp_order_q <= exp_order_d;
      if (pop)      commit_count_q <= commit_count_q + ORDER_W'(1);
      if (new_halt) halt_seen_q    <= 1'b1;
      if (err_any) begin
        error_q <= 1'b1;
        if (!error_q) error_code_q <= code_d;
      end
    end
  end

  // Storage needs no reset: pointers and count define what is live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (wr_en[i]) mem_q[wr_slot[i]] <= lane_e[i];
    end
  end

  always_comb begin
    head_e = '0;
    if (out_valid) head_e = mem_q[head_q];
  end

  assign out_order        = head_e.order;
  assign out_inst         = head_e.inst;
  assign out_pc_rdata     = head_e.pc_rdata;
  assign out_pc_wdata     = head_e.pc_wdata;
  assign out_load_regfile = head_e.load_regfile;
  assign out_rd_addr      = head_e.rd_addr;
  assign out_rd_wdata     = head_e.rd_wdata;
  assign out_halt         = head_e.halt;
  assign in_ready         = in_ready_q;
  assign commit_count     = commit_count_q;
  assign halt_seen        = halt_seen_q;
  assign error            = error_q;
  assign error_code       = error_code_q;

endmodule

// File: tb/tb_mon_commit_serializer.sv
// Directed bench for mon_commit_serializer: expected packets queue on issue and
// a negedge monitor compares every popped head entry against the queue.
module tb_mon_commit_serializer;
  localparam int CH = 2;
  localparam int XL = 32;
  localparam int OW = 64;
  localparam int PW = OW + 32 + XL + XL + 1 + 5 + XL + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [CH-1:0]     in_valid;
  logic [CH*OW-1:0]  in_order;
  logic [CH*32-1:0]  in_inst;
  logic [CH*XL-1:0]  in_pc_rdata, in_pc_wdata, in_rd_wdata;
  logic [CH-1:0]     in_load_regfile, in_halt;
  logic [CH*5-1:0]   in_rd_addr;
  logic              in_ready, out_valid, out_ready;
  logic [OW-1:0]     out_order, commit_count;
  logic [31:0]       out_inst;
  logic [XL-1:0]     out_pc_rdata, out_pc_wdata, out_rd_wdata;
  logic              out_load_regfile, out_halt, halt_seen, error;
  logic [4:0]        out_rd_addr;
  logic [1:0]        error_code;

  logic [PW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  mon_commit_serializer #(.CHANNELS(CH), .DEPTH(8), .XLEN(XL), .ORDER_W(OW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_order(in_order), .in_inst(in_inst),
    .in_pc_rdata(in_pc_rdata), .in_pc_wdata(in_pc_wdata),
    .in_load_regfile(in_load_regfile), .in_rd_addr(in_rd_addr),
    .in_rd_wdata(in_rd_wdata), .in_halt(in_halt), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_order(out_order),
    .out_inst(out_inst), .out_pc_rdata(out_pc_rdata), .out_pc_wdata(out_pc_wdata),
    .out_load_regfile(out_load_regfile), .out_rd_addr(out_rd_addr),
    .out_rd_wdata(out_rd_wdata), .out_halt(out_halt),
    .commit_count(commit_count), .halt_seen(halt_seen),
    .error(error), .error_code(error_code)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Packet contents are derived from the order number so every field is distinct.
  function automatic logic [PW-1:0] mk(input logic [63:0] o, input logic h);
    logic [31:0] inst, pc, rdw;
    inst = {o[15:0], 16'h0013};
    pc   = 32'h0000_1000 + {o[29:0], 2'b00};
    rdw  = o[31:0] ^ 32'hA5A5_0000;
    return {o, inst, pc, pc + 32'd4, o[0], o[4:0], rdw, h};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Driver tasks
  task automatic set_lane(input int i, input logic [63:0] o, input logic h);
    logic [31:0] pc;
    pc = 32'h0000_1000 + {o[29:0], 2'b00};
    in_order[i*OW +: OW]    = o;
    in_inst[i*32 +: 32]     = {o[15:0], 16'h0013};
    in_pc_rdata[i*XL +: XL] = pc;
    in_pc_wdata[i*XL +: XL] = pc + 32'd4;
    in_load_regfile[i]      = o[0];
    in_rd_addr[i*5 +: 5]    = o[4:0];
    in_rd_wdata[i*XL +: XL] = o[31:0] ^ 32'hA5A5_0000;
    in_halt[i]              = h;
  endtask

  task automatic drive(input logic [1:0] v, input logic [63:0] o0, input logic [63:0] o1,
                       input logic [1:0] h, input bit acc);
    set_lane(0, o0, h[0]);
    set_lane(1, o1, h[1]);
    in_valid = v;
    if (acc) begin
      if (v[0]) exp_q.push_back(mk(o0, h[0]));
      if (v[1]) exp_q.push_back(mk(o1, h[1]));
    end
    @(posedge clk); #1;
    in_valid = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = '0;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_drain: %0d packets still expected after %0d cycles", name, exp_q.size(), n);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got order %0h expected no packet", out_order);
      end else begin
        logic [PW-1:0] act, expv;
        act  = {out_order, out_inst, out_pc_rdata, out_pc_wdata, out_load_regfile,
                out_rd_addr, out_rd_wdata, out_halt};
        expv = exp_q.pop_front();
        if (act !== expv) begin
          n_fail++;
          $display("FAIL pop_packet: got %0h expected %0h", act, expv);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    in_valid = '0; in_order = '0; in_inst = '0; in_pc_rdata = '0; in_pc_wdata = '0;
    in_load_regfile = '0; in_rd_addr = '0; in_rd_wdata = '0; in_halt = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_order", out_order, 0);
    check("rst_commit_count", commit_count, 0);
    check("rst_error", error, 0);
    check("rst_error_code", error_code, 0);
    check("rst_halt_seen", halt_seen, 0);

    // Two lanes in one cycle, drained back to back
    out_ready = 1'b1;
    drive(2'b11, 64'd0, 64'd1, 2'b00, 1);
    check("t1_out_valid_next", out_valid, 1);
    check("t1_head_order", out_order, 0);
    wait_drain("t1");
    check("t1_commit_count", commit_count, 2);
    check("t1_error", error, 0);
    check("t1_empty_out_rd_wdata", out_rd_wdata, 0);

    // Non-contiguous lane masks
    do_reset();
    out_ready = 1'b1;
    drive(2'b10, 64'd99, 64'd0, 2'b00, 1);
    drive(2'b01, 64'd1, 64'd77, 2'b00, 1);
    wait_drain("t2");
    check("t2_error", error, 0);
    check("t2_commit_count", commit_count, 2);

    // Order gap: code latches once, gap entry still emitted
    do_reset();
    out_ready = 1'b1;
    drive(2'b11, 64'd0, 64'd1, 2'b00, 1);
    drive(2'b11, 64'd3, 64'd4, 2'b00, 1);
    check("t3_error", error, 1);
    check("t3_error_code", error_code, 1);
    drive(2'b01, 64'd5, 64'd0, 2'b00, 1);
    wait_drain("t3");
    check("t3_error_code_kept", error_code, 1);
    check("t3_commit_count", commit_count, 5);

    // Fill to DEPTH with ready low, then overflow
    do_reset();
    out_ready = 1'b0;
    drive(2'b11, 64'd0, 64'd1, 2'b00, 1);
    drive(2'b11, 64'd2, 64'd3, 2'b00, 1);
    drive(2'b11, 64'd4, 64'd5, 2'b00, 1);
    check("t4_in_ready_at6", in_ready, 1);
    drive(2'b11, 64'd6, 64'd7, 2'b00, 1);
    check("t4_in_ready_at8", in_ready, 0);
    check("t4_error_before", error, 0);
    drive(2'b11, 64'd8, 64'd9, 2'b00, 0);
    check("t4_error", error, 1);
    check("t4_error_code", error_code, 2);
    out_ready = 1'b1;
    wait_drain("t4");
    check("t4_commit_count", commit_count, 8);
    check("t4_out_valid_empty", out_valid, 0);

    // Halt on lane 0 with lane 1 in the same cycle
    do_reset();
    out_ready = 1'b1;
    drive(2'b11, 64'd0, 64'd1, 2'b01, 1);
    check("t5_halt_seen", halt_seen, 1);
    check("t5_error", error, 1);
    check("t5_error_code", error_code, 3);
    wait_drain("t5");
    check("t5_commit_count", commit_count, 2);

    // Reset while five entries are buffered
    do_reset();
    out_ready = 1'b0;
    drive(2'b11, 64'd0, 64'd1, 2'b00, 1);
    drive(2'b11, 64'd2, 64'd3, 2'b00, 1);
    drive(2'b01, 64'd4, 64'd0, 2'b00, 1);
    check("t6_out_valid_before", out_valid, 1);
    do_reset();
    check("t6_out_valid", out_valid, 0);
    check("t6_error", error, 0);
    check("t6_in_ready", in_ready, 1);
    check("t6_commit_count", commit_count, 0);
    out_ready = 1'b1;
    drive(2'b01, 64'd0, 64'd0, 2'b00, 1);
    wait_drain("t6");
    check("t6_error_after", error, 0);
    check("t6_commit_after", commit_count, 1);
    check("t6_out_valid_end", out_valid, 0);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
